// File: rtl/pcie_msi_moderator.sv
// pcie_msi_moderator
// Per-vector MSI interrupt moderation. Each vector collects event pulses and
// raises a single one-cycle request to the MSI shim once its holdoff timer
// expires or its event count reaches the programmed threshold.
//
// Ports
//   clk, rst        : sole clock, synchronous active-high reset
//   event_in        : per-vector one-cycle event pulses
//   msi_enable      : global interrupt enable (PF0 MSI enable)
//   cfg_wr_en       : per-vector config write strobe
//   cfg_wr_vector   : vector index written (indexes >= MSI_COUNT are ignored)
//   cfg_wr_holdoff  : holdoff in prescaler ticks
//   cfg_wr_thresh   : event-count trigger, 0 disables the count trigger
//   msi_irq         : registered one-cycle request pulses
//   pending         : registered per-vector pending status
module pcie_msi_moderator #(
    parameter int MSI_COUNT   = 32,
    parameter int TIMER_WIDTH = 16,
    parameter int COUNT_WIDTH = 8,
    parameter int PRESCALE    = 250
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MSI_COUNT-1:0]   event_in,
    input  logic                   msi_enable,
    input  logic                   cfg_wr_en,
    input  logic [4:0]             cfg_wr_vector,
    input  logic [TIMER_WIDTH-1:0] cfg_wr_holdoff,
    input  logic [COUNT_WIDTH-1:0] cfg_wr_thresh,
    output logic [MSI_COUNT-1:0]   msi_irq,
    output logic [MSI_COUNT-1:0]   pending
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]          presc_q, presc_d;
    logic                   tick_s;

    logic [MSI_COUNT-1:0]   pend_q, pend_d;
    logic [MSI_COUNT-1:0]   irq_q, irq_d;
    logic [COUNT_WIDTH-1:0] count_q   [MSI_COUNT];
    logic [COUNT_WIDTH-1:0] count_d   [MSI_COUNT];
    logic [TIMER_WIDTH-1:0] timer_q   [MSI_COUNT];
    logic [TIMER_WIDTH-1:0] timer_d   [MSI_COUNT];
    logic [TIMER_WIDTH-1:0] holdoff_q [MSI_COUNT];
    logic [TIMER_WIDTH-1:0] holdoff_d [MSI_COUNT];
    logic [COUNT_WIDTH-1:0] thresh_q  [MSI_COUNT];
    logic [COUNT_WIDTH-1:0] thresh_d  [MSI_COUNT];

    // State after this cycle's event/tick update, before any fire decision.
    logic [MSI_COUNT-1:0]   pend_upd_s;
    logic [COUNT_WIDTH-1:0] cnt_upd_s [MSI_COUNT];
    logic [TIMER_WIDTH-1:0] tmr_upd_s [MSI_COUNT];
    logic [MSI_COUNT-1:0]   elig_s;
    logic [MSI_COUNT-1:0]   elig_wo_evt_s;
    logic [MSI_COUNT-1:0]   fire_s;

    // Prescaler: wraps at PRESCALE-1 and emits one tick on the wrap cycle.
    always_comb begin
        tick_s = (presc_q == PW'(PRESCALE - 1));
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Per-vector IDLE/PEND update, eligibility and fire decision.
    always_comb begin
        pend_upd_s    = '0;
        elig_s        = '0;
        elig_wo_evt_s = '0;
        fire_s        = '0;
        pend_d        = '0;
        irq_d         = '0;
        for (int v = 0; v < MSI_COUNT; v++) begin
            cnt_upd_s[v] = count_q[v];
            tmr_upd_s[v] = timer_q[v];
            count_d[v]   = count_q[v];
            timer_d[v]   = timer_q[v];

            if (pend_q[v]) begin
                pend_upd_s[v] = 1'b1;
                if (event_in[v] && (count_q[v] != {COUNT_WIDTH{1'b1}})) begin
                    cnt_upd_s[v] = count_q[v] + COUNT_WIDTH'(1);
                end else begin
                    cnt_upd_s[v] = count_q[v];
                end
                if (tick_s && (timer_q[v] != '0)) begin
                    tmr_upd_s[v] = timer_q[v] - TIMER_WIDTH'(1);
                end else begin
                    tmr_upd_s[v] = timer_q[v];
                end
            end else if (event_in[v]) begin
                pend_upd_s[v] = 1'b1;
                cnt_upd_s[v]  = COUNT_WIDTH'(1);
                tmr_upd_s[v]  = holdoff_q[v];
            end else begin
                pend_upd_s[v] = 1'b0;
            end

            elig_s[v] = pend_upd_s[v] &&
                        ((tmr_upd_s[v] == '0) ||
                         ((thresh_q[v] != '0) && (cnt_upd_s[v] >= thresh_q[v])));
            // Would the vector have fired without this cycle's event? If so,
            // that event is not part of the delivery and opens a new PEND.
            elig_wo_evt_s[v] = pend_q[v] &&
                               ((tmr_upd_s[v] == '0) ||
                                ((thresh_q[v] != '0) && (count_q[v] >= thresh_q[v])));
            fire_s[v] = elig_s[v] && msi_enable && !irq_q[v];

            if (fire_s[v]) begin
                irq_d[v] = 1'b1;
                if (event_in[v] && elig_wo_evt_s[v]) begin
                    pend_d[v]  = 1'b1;
                    count_d[v] = COUNT_WIDTH'(1);
                    timer_d[v] = holdoff_q[v];
                end else begin
                    pend_d[v]  = 1'b0;
                    count_d[v] = '0;
                    timer_d[v] = '0;
                end
            end else begin
                irq_d[v]   = 1'b0;
                pend_d[v]  = pend_upd_s[v];
                count_d[v] = cnt_upd_s[v];
                timer_d[v] = tmr_upd_s[v];
            end
        end
    end

    // Config write decode; unmatched indexes leave every vector unchanged.
    always_comb begin
        for (int v = 0; v < MSI_COUNT; v++) begin
            if (cfg_wr_en && (cfg_wr_vector == 5'(v))) begin
                holdoff_d[v] = cfg_wr_holdoff;
                thresh_d[v]  = cfg_wr_thresh;
            end else begin
                holdoff_d[v] = holdoff_q[v];
                thresh_d[v]  = thresh_q[v];
            end
        end
    end

    // State registers; reset restores pass-through config (holdoff 0, thresh 1).
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            pend_q  <= '0;
            irq_q   <= '0;
            for (int v = 0; v < MSI_COUNT; v++) begin
                count_q[v]   <= '0;
                timer_q[v]   <= '0;
                holdoff_q[v] <= '0;
                thresh_q[v]  <= COUNT_WIDTH'(1);
            end
        end else begin
            presc_q <= presc_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
            for (int v = 0; v < MSI_COUNT; v++) begin
                count_q[v]   <= count_d[v];
                timer_q[v]   <= timer_d[v];
                holdoff_q[v] <= holdoff_d[v];
                thresh_q[v]  <= thresh_d[v];
            end
        end
    end

    assign msi_irq = irq_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_pcie_msi_moderator.sv
// Testbench for pcie_msi_moderator. Two instances (PRESCALE 1 and 3) share
// one stimulus stream. A behavioural model predicts each cycle's outputs and
// pushes them into a scoreboard queue; a monitor pops and compares.
module tb_pcie_msi_moderator;

    localparam int N    = 8;
    localparam int TW   = 16;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  event_in;
    logic          msi_enable;
    logic          cfg_wr_en;
    logic [4:0]    cfg_wr_vector;
    logic [TW-1:0] cfg_wr_holdoff;
    logic [CW-1:0] cfg_wr_thresh;
    logic [N-1:0]  irq_a, pend_a, irq_b, pend_b;

    always #5 clk = ~clk;

    pcie_msi_moderator #(.MSI_COUNT(N), .TIMER_WIDTH(TW), .COUNT_WIDTH(CW), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .event_in(event_in), .msi_enable(msi_enable),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_vector(cfg_wr_vector),
        .cfg_wr_holdoff(cfg_wr_holdoff), .cfg_wr_thresh(cfg_wr_thresh),
        .msi_irq(irq_a), .pending(pend_a));

    pcie_msi_moderator #(.MSI_COUNT(N), .TIMER_WIDTH(TW), .COUNT_WIDTH(CW), .PRESCALE(3)) dut_b (
        .clk(clk), .rst(rst), .event_in(event_in), .msi_enable(msi_enable),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_vector(cfg_wr_vector),
        .cfg_wr_holdoff(cfg_wr_holdoff), .cfg_wr_thresh(cfg_wr_thresh),
        .msi_irq(irq_b), .pending(pend_b));

    typedef struct packed {
        logic [N-1:0] irq_a;
        logic [N-1:0] pend_a;
        logic [N-1:0] irq_b;
        logic [N-1:0] pend_b;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    logic cur_en;

    // Reference model: per instance, per vector bookkeeping in plain integers.
    int m_pend [2][N];
    int m_cnt  [2][N];
    int m_tmr  [2][N];
    int m_hold [2][N];
    int m_thr  [2][N];
    int m_irq  [2][N];
    int m_presc[2];

    function automatic int presc_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic model_step(input logic r, input logic [N-1:0] ev, input logic en,
                              input logic wr, input int vec, input int hold, input int thr);
        logic [N-1:0] ni [2];
        logic [N-1:0] np [2];
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            ni[i] = '0;
            np[i] = '0;
            if (r) begin
                m_presc[i] = 0;
                for (int v = 0; v < N; v++) begin
                    m_pend[i][v] = 0; m_cnt[i][v] = 0; m_tmr[i][v] = 0;
                    m_hold[i][v] = 0; m_thr[i][v] = 1; m_irq[i][v] = 0;
                end
            end else begin
                bit tick;
                tick = (m_presc[i] == presc_of(i) - 1);
                m_presc[i] = tick ? 0 : m_presc[i] + 1;
                for (int v = 0; v < N; v++) begin
                    int  old_cnt;
                    bit  was_pend, ready, ready_wo, fire;
                    old_cnt  = m_cnt[i][v];
                    was_pend = (m_pend[i][v] != 0);
                    if (was_pend) begin
                        if (ev[v]) m_cnt[i][v] = (m_cnt[i][v] + 1 > CMAX) ? CMAX : m_cnt[i][v] + 1;
                        if (tick && m_tmr[i][v] > 0) m_tmr[i][v]--;
                    end else if (ev[v]) begin
                        m_pend[i][v] = 1; m_cnt[i][v] = 1; m_tmr[i][v] = m_hold[i][v];
                    end
                    ready    = (m_pend[i][v] != 0) && (m_tmr[i][v] == 0 ||
                               (m_thr[i][v] > 0 && m_cnt[i][v] >= m_thr[i][v]));
                    ready_wo = was_pend && (m_tmr[i][v] == 0 ||
                               (m_thr[i][v] > 0 && old_cnt >= m_thr[i][v]));
                    fire     = ready && en && (m_irq[i][v] == 0);
                    if (fire) begin
                        if (ev[v] && ready_wo) begin
                            m_pend[i][v] = 1; m_cnt[i][v] = 1; m_tmr[i][v] = m_hold[i][v];
                        end else begin
                            m_pend[i][v] = 0; m_cnt[i][v] = 0;
                        end
                    end
                    m_irq[i][v] = fire ? 1 : 0;
                    ni[i][v] = fire;
                    np[i][v] = (m_pend[i][v] != 0);
                end
                if (wr && vec < N) begin
                    m_hold[i][vec] = hold;
                    m_thr[i][vec]  = thr;
                end
            end
        end
        e.irq_a = ni[0]; e.pend_a = np[0]; e.irq_b = ni[1]; e.pend_b = np[1];
        sb_q.push_back(e);
    endtask

    // One stimulus cycle: drive at the falling edge and predict the next outputs.
    task automatic drive(input logic r, input logic [N-1:0] ev, input logic wr,
                         input int vec, input int hold, input int thr);
        @(negedge clk);
        rst            = r;
        event_in       = ev;
        msi_enable     = cur_en;
        cfg_wr_en      = wr;
        cfg_wr_vector  = 5'(vec);
        cfg_wr_holdoff = TW'(hold);
        cfg_wr_thresh  = CW'(thr);
        model_step(r, ev, cur_en, wr, vec, hold, thr);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0, 0, 0, 0);
    endtask

    task automatic ev_pulse(input logic [N-1:0] ev);
        drive(1'b0, ev, 1'b0, 0, 0, 0);
    endtask

    task automatic cfg(input int vec, input int hold, input int thr);
        drive(1'b0, '0, 1'b1, vec, hold, thr);
    endtask

    // Monitor: compare DUT outputs against the oldest prediction.
    initial begin
        exp_t         e;
        logic [N-1:0] prev_a, prev_b;
        prev_a = '0;
        prev_b = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (irq_a !== e.irq_a) begin
                    errors++;
                    $display("FAIL irq_p1 t=%0t got=%h exp=%h", $time, irq_a, e.irq_a);
                end
                checks++;
                if (pend_a !== e.pend_a) begin
                    errors++;
                    $display("FAIL pending_p1 t=%0t got=%h exp=%h", $time, pend_a, e.pend_a);
                end
                checks++;
                if (irq_b !== e.irq_b) begin
                    errors++;
                    $display("FAIL irq_p3 t=%0t got=%h exp=%h", $time, irq_b, e.irq_b);
                end
                checks++;
                if (pend_b !== e.pend_b) begin
                    errors++;
                    $display("FAIL pending_p3 t=%0t got=%h exp=%h", $time, pend_b, e.pend_b);
                end
                checks++;
                if (((irq_a & prev_a) | (irq_b & prev_b)) !== '0) begin
                    errors++;
                    $display("FAIL back_to_back t=%0t got=%h/%h exp=00", $time,
                             irq_a & prev_a, irq_b & prev_b);
                end
                prev_a = irq_a;
                prev_b = irq_b;
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized soak.
    initial begin
        int waited;
        rst = 1'b1; event_in = '0; msi_enable = 1'b0; cfg_wr_en = 1'b0;
        cfg_wr_vector = '0; cfg_wr_holdoff = '0; cfg_wr_thresh = '0;
        cur_en = 1'b0;

        repeat (3) drive(1'b1, '0, 1'b0, 0, 0, 0);

        // Pass-through after reset.
        cur_en = 1'b1;
        idle(2);
        ev_pulse(8'h01);
        idle(4);

        // Holdoff timer only; extra events inside the window do not reload.
        cfg(3, 10, 0);
        ev_pulse(8'h08);
        idle(2);
        ev_pulse(8'h08);
        idle(1);
        ev_pulse(8'h08);
        idle(40);

        // Count trigger with long holdoff.
        cfg(5, 1000, 4);
        repeat (4) ev_pulse(8'h20);
        idle(6);
        cfg(5, 0, 1);

        // Back-to-back events on a pass-through vector.
        repeat (10) ev_pulse(8'h01);
        idle(3);

        // Enable gating.
        cur_en = 1'b0;
        ev_pulse(8'h81);
        idle(3);
        cur_en = 1'b1;
        idle(3);

        // Count saturation: 20 events with threshold at the counter maximum.
        cfg(1, 200, CMAX);
        cur_en = 1'b0;
        repeat (20) ev_pulse(8'h02);
        cur_en = 1'b1;
        idle(3);

        // Threshold lowered while a vector is pending applies immediately.
        cfg(4, 300, 0);
        repeat (3) ev_pulse(8'h10);
        idle(2);
        cfg(4, 300, 2);
        idle(3);

        // Out-of-range config index is ignored.
        cfg(13, 500, 0);
        cfg(N + 2, 500, 0);
        ev_pulse(8'hff);
        idle(3);

        // Reset in the middle of a holdoff window.
        cfg(2, 50, 0);
        ev_pulse(8'h04);
        idle(20);
        repeat (2) drive(1'b1, 8'h04, 1'b1, 2, 7, 0);
        idle(320);
        ev_pulse(8'h04);
        idle(3);

        // Randomized soak.
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] ev;
            ev = N'($urandom) & N'($urandom) & N'($urandom);
            cur_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 399) == 0) begin
                drive(1'b1, ev, 1'b0, 0, 0, 0);
            end else if ($urandom_range(0, 19) == 0) begin
                drive(1'b0, ev, 1'b1, $urandom_range(0, 11),
                      $urandom_range(0, 12), $urandom_range(0, 5));
            end else begin
                drive(1'b0, ev, 1'b0, 0, 0, 0);
            end
        end
        cur_en = 1'b1;
        idle(5);

        waited = 0;
        while (sb_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
